// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings for the memory stage: major opcodes, load/store
// width codes (funct3), memory FSM state encoding, and the store byte-enable
// helper.
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Byte enables for a store of the given width at byte offset off.
  function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                          input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = 4'b0011 << off;
      default: store_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment and extension.
// Ports:
//   rdata  - raw 32-bit word from data memory
//   offset - byte offset of the access within the word
//   funct3 - load width/signedness code
//   data   - right-justified, sign- or zero-extended load result
module load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: EX/MEM pipeline register, data-memory access control
// with a variable-latency ack handshake, and the MEM/WB register.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access outstanding beyond the current cycle
// WAIT    | aligned load/store issued, ack not yet seen; pipeline held
//
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   valid_in .. reg_wr_addr     - instruction fields from EX
//   dmem_*                      - data-memory request/response
//   wb_*                        - registered write-back outputs
//   stall                       - hold EX and earlier stages
module mem_stage
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] pc,
  input  logic        jump_or_branch,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [4:0]  reg_wr_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_misalign,
  output logic        wb_jump_or_branch,
  output logic        stall
);

  logic        valid_q;
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic [31:0] pc_q;
  logic        jb_q;
  logic [31:0] b_q;
  logic [31:0] c_q;
  logic [4:0]  rd_q;

  mem_state_e  state_q, state_d;

  logic        is_load, is_store, is_jump, writes_rd;
  logic        misaligned, mem_access;
  logic [1:0]  offset;
  logic [31:0] load_data;

  // EX/MEM register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      funct3_q <= '0;
      pc_q     <= '0;
      jb_q     <= 1'b0;
      b_q      <= '0;
      c_q      <= '0;
      rd_q     <= '0;
    end else if (!stall) begin
      valid_q  <= valid_in;
      opcode_q <= opcode;
      funct3_q <= funct3;
      pc_q     <= pc;
      jb_q     <= jump_or_branch;
      b_q      <= b;
      c_q      <= c;
      rd_q     <= reg_wr_addr;
    end
  end

  assign offset   = c_q[1:0];
  assign is_load  = (opcode_q == OPC_LOAD);
  assign is_store = (opcode_q == OPC_STORE);
  assign is_jump  = (opcode_q == OPC_JAL) || (opcode_q == OPC_JALR);

  always_comb begin
    writes_rd = 1'b0;
    case (opcode_q)
      OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP:
        writes_rd = 1'b1;
      default:
        writes_rd = 1'b0;
    endcase
  end

  // Alignment only matters for memory ops; funct3 means something else
  // for the ALU opcodes.
  always_comb begin
    misaligned = 1'b0;
    if (is_load || is_store) begin
      case (funct3_q[1:0])
        2'b01:   misaligned = offset[0];
        2'b10:   misaligned = (offset != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
  end

  assign mem_access = valid_q & (is_load | is_store) & ~misaligned;

  // Request fields derive only from the EX/MEM register, which is frozen
  // while stalled, so they stay stable until the ack cycle.
  assign dmem_addr  = {c_q[31:2], 2'b00};
  assign dmem_we    = mem_access & is_store;
  assign dmem_be    = is_store ? store_be(funct3_q, offset) : 4'b1111;

  always_comb begin
    dmem_wdata = b_q;
    if (funct3_q[1] == 1'b0)
      dmem_wdata = b_q << {offset, 3'b000};
  end

  // Access FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_access) begin
          dmem_req = 1'b1;
          if (!dmem_ack) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall = dmem_req & ~dmem_ack;

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (offset),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  // MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid          <= 1'b0;
      wb_we             <= 1'b0;
      wb_rd             <= '0;
      wb_data           <= '0;
      wb_misalign       <= 1'b0;
      wb_jump_or_branch <= 1'b0;
    end else if (!stall) begin
      wb_valid          <= valid_q;
      wb_we             <= valid_q & writes_rd & ~misaligned & (rd_q != 5'd0);
      wb_rd             <= rd_q;
      wb_misalign       <= valid_q & misaligned;
      wb_jump_or_branch <= jb_q;
      if (is_load)      wb_data <= load_data;
      else if (is_jump) wb_data <= pc_q + 32'd4;
      else              wb_data <= c_q;
    end
  end

endmodule
